pipe_stage_elastic: RTL and testbench
=====================================

# pipe_stage_elastic

Parametrised, elastic inter-stage pipeline register for the processor datapath (ID/EX, EX/MEM, MEM/WB and similar). It carries an arbitrary-width bundle between stages with a valid/ready handshake, an optional 2-entry skid buffer for full throughput under back-pressure, a synchronous flush that inserts a bubble, and a programmable reset/bubble value. It replaces hand-sized stage registers that have only a plain enable and reset.

## Interface
- WIDTH, 111: payload width in bits; any value ≥ 1.
- RESET_VAL, {WIDTH{1'b0}}: value of the main data register after reset and after flush (NOP encoding).
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- reloj  input  1  clock; all state changes on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept a beat this cycle.
- in_data  input  WIDTH  upstream payload.
- flush  input  1  synchronous kill of all held and incoming beats.
- out_valid  output  1  beat presented downstream.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  WIDTH  payload presented downstream.
- occupancy  output  2  beats held: 0, 1 or 2; 2 only when SKID=1.

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State register: EMPTY (occupancy 0), ONE (main full), TWO (main and skid full; SKID=1 only).
- out_valid = (state != EMPTY); out_data = main register at all times, including when EMPTY.
- SKID=1: in_ready = (state != TWO), taken directly from a flop (no combinational path from out_ready).
- SKID=0: in_ready = !out_valid | out_ready (combinational); state TWO is unreachable.
- Transitions when flush=0:
  - EMPTY: in_fire → ONE, main ← in_data.
  - ONE: in_fire & out_fire → ONE, main ← in_data; in_fire & !out_ready → TWO, skid ← in_data (SKID=1); !in_fire & out_fire → EMPTY; otherwise hold.
  - TWO: out_fire → ONE, main ← skid; otherwise hold. No input accepted.
- flush=1 has priority over everything: next state EMPTY, main ← RESET_VAL, skid content is don't-care; any beat that fires on that edge is discarded; a beat that fires downstream on that edge counts as delivered.
- Ordering: beats leave in acceptance order; none are duplicated or dropped, except by flush.
- occupancy = 0/1/2 for EMPTY/ONE/TWO.

## Timing
- Reset (resetn=0, asynchronous): state EMPTY, out_valid=0, out_data=RESET_VAL, occupancy=0, in_ready=1.
- Latency: a beat accepted on edge N appears on out_data with out_valid=1 after edge N (one cycle).
- Throughput: one beat per cycle while out_ready=1, for both SKID values.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged until out_fire or flush.
- SKID=1 back-pressure: when out_ready drops with a continuous input stream, exactly one extra beat is absorbed (TWO); in_ready goes low after that edge.
- Release from TWO: the first out_fire moves skid to main; in_ready is 1 in the next cycle.
- Flush on the same edge as in_fire and out_fire: output beat delivered, input beat dropped, state EMPTY, occupancy 0 next cycle.
- resetn asserted mid-stream: all state clears immediately without waiting for a clock; held beats are lost.
- in_data and in_valid are ignored when in_ready=0.

## Test plan
- Reset: resetn=0 with random inputs, then release → out_valid=0, occupancy=0, in_ready=1, out_data=RESET_VAL (for example WIDTH=8, RESET_VAL=8'hA5 → 8'hA5).
- Streaming, SKID=1: out_ready=1, send 0x01..0x10 back-to-back → 16 beats out in order, each one cycle after acceptance, occupancy never exceeds 1.
- Back-pressure, SKID=1: stream 0x01, 0x02, 0x03 with out_ready=0 from cycle 1 → occupancy reaches 2, in_ready=0, 0x03 waits upstream; set out_ready=1 → output sequence 0x01, 0x02, 0x03 with no gaps.
- Flush: occupancy=2 holding 0x11 and 0x22, assert flush with in_valid=1 and in_data=0x33 → next cycle occupancy=0, out_valid=0, out_data=RESET_VAL; 0x11, 0x22 and 0x33 never appear.
- SKID=0: out_ready=0 with out_valid=1 → in_ready=0 in the same cycle; raise out_ready → in_ready=1 combinationally, and an accept plus deliver in one cycle keeps occupancy at 1.
- Asynchronous reset mid-stream: drop resetn between clock edges while occupancy=2 → out_valid falls before the next edge, occupancy=0, and output resumes correctly with the next beat after release.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_elastic
// Brief    : Elastic inter-stage pipeline register with valid/ready handshake,
//            optional 2-entry skid buffer, synchronous flush and bubble value.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_elastic #(
    parameter int              WIDTH     = 111,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter bit              SKID      = 1'b1
) (
    input  logic             reloj,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // Encoding doubles as the occupancy count.
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_TWO   = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;

    assign out_valid  = (r_state != c_EMPTY);
    assign out_data   = r_main;
    assign occupancy  = r_state;
    assign in_ready   = w_in_ready;
    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = c_EMPTY;
            w_main_nxt  = RESET_VAL;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = c_ONE;
                        w_main_nxt  = in_data;
                    end
                end
                c_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = in_data;
                    end else if (w_in_fire && SKID) begin
                        w_state_nxt = c_TWO;
                        w_skid_nxt  = in_data;
                    end else if (w_out_fire) begin
                        w_state_nxt = c_EMPTY;
                    end
                end
                c_TWO: begin
                    if (w_out_fire) begin
                        w_state_nxt = c_ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = c_EMPTY;
                    w_main_nxt  = RESET_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge reloj or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_EMPTY;
            r_main  <= RESET_VAL;
            r_skid  <= {WIDTH{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    generate
        if (SKID) begin : g_skid
            // Registered ready breaks the out_ready -> in_ready timing path.
            logic r_in_ready;
            always_ff @(posedge reloj or negedge resetn) begin
                if (!resetn) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_nxt != c_TWO);
                end
            end
            assign w_in_ready = r_in_ready;
        end else begin : g_no_skid
            assign w_in_ready = !out_valid | out_ready;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_elastic
// Brief    : Self-checking bench; SKID=1 and SKID=0 instances share stimulus
//            and are each compared against a FIFO-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_elastic;

    localparam logic [7:0] c_RST = 8'hA5;

    logic       reloj = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;

    logic       w_in_ready_s, w_out_valid_s, w_in_ready_n, w_out_valid_n;
    logic [7:0] w_out_data_s, w_out_data_n;
    logic [1:0] w_occ_s, w_occ_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: index 0 = SKID=1 instance, index 1 = SKID=0 instance.
    int         m_cnt [2];
    logic [7:0] m_buf [2][2];
    logic [7:0] m_idle[2];

    always #5 reloj = ~reloj;

    pipe_stage_elastic #(.WIDTH(8), .RESET_VAL(c_RST), .SKID(1'b1)) u_dut_skid (
        .reloj(reloj), .resetn(resetn), .in_valid(in_valid), .in_ready(w_in_ready_s),
        .in_data(in_data), .flush(flush), .out_valid(w_out_valid_s), .out_ready(out_ready),
        .out_data(w_out_data_s), .occupancy(w_occ_s)
    );

    pipe_stage_elastic #(.WIDTH(8), .RESET_VAL(c_RST), .SKID(1'b0)) u_dut_noskid (
        .reloj(reloj), .resetn(resetn), .in_valid(in_valid), .in_ready(w_in_ready_n),
        .in_data(in_data), .flush(flush), .out_valid(w_out_valid_n), .out_ready(out_ready),
        .out_data(w_out_data_n), .occupancy(w_occ_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_ready(input int k);
        if (k == 0) return (m_cnt[0] < 2);
        return (m_cnt[1] == 0) || out_ready;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = 0;
            m_idle[k] = c_RST;
        end
    endtask

    task automatic model_clock();
        for (int k = 0; k < 2; k++) begin
            logic ifire, ofire;
            ifire = in_valid && model_ready(k);
            ofire = (m_cnt[k] > 0) && out_ready;
            if (flush) begin
                m_cnt[k]  = 0;
                m_idle[k] = c_RST;
            end else begin
                if (ofire) begin
                    m_idle[k]   = m_buf[k][0];
                    m_buf[k][0] = m_buf[k][1];
                    m_cnt[k]--;
                end
                if (ifire) begin
                    m_buf[k][m_cnt[k]] = in_data;
                    m_cnt[k]++;
                end
            end
        end
    endtask

    task automatic check_dut(input int k, input string name, input logic vld, input logic rdy,
                             input logic [7:0] data, input logic [1:0] occ);
        check({name, ".out_valid"}, vld, m_cnt[k] > 0);
        check({name, ".out_data"}, data, (m_cnt[k] > 0) ? m_buf[k][0] : m_idle[k]);
        check({name, ".occupancy"}, occ, m_cnt[k]);
        check({name, ".in_ready"}, rdy, model_ready(k));
    endtask

    task automatic check_all();
        check_dut(0, "skid", w_out_valid_s, w_in_ready_s, w_out_data_s, w_occ_s);
        check_dut(1, "noskid", w_out_valid_n, w_in_ready_n, w_out_data_n, w_occ_n);
    endtask

    // Called at a falling edge: drive, check after settling, then clock the model.
    task automatic step(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_all();
        @(posedge reloj);
        if (!resetn) model_reset();
        else model_clock();
        @(negedge reloj);
    endtask

    initial begin
        logic [7:0] pend;
        model_reset();
        @(negedge reloj);
        // Reset held with random inputs
        for (int i = 0; i < 4; i++)
            step(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        resetn = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Back-to-back streaming at full throughput
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Back-pressure: 0x03 held upstream until the skid instance takes it
        step(1'b1, 8'h01, 1'b1, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        check("skid.bp_full", w_occ_s, 2'd2);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h03, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush while the skid instance holds two beats
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b1);
        check("skid.flush_data", w_out_data_s, c_RST);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush coinciding with in_fire and out_fire
        step(1'b1, 8'h40, 1'b1, 1'b0);
        step(1'b1, 8'h41, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset between edges while two beats are held
        step(1'b1, 8'h44, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 resetn = 1'b1;
        @(negedge reloj);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h66 + i), 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic; data only advances once the skid instance accepts it
        pend = 8'($urandom);
        for (int i = 0; i < 400; i++) begin
            logic v, accept;
            v = 1'($urandom_range(0, 3) != 0);
            accept = v && model_ready(0);
            step(v, pend, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
            if (accept) pend = 8'($urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
